// File: rtl/gray_counter.sv
// Up/down binary counter with a registered reflected-Gray copy.
// Supports binary or Gray load, direction control and wrap pulse.
module gray_counter #(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic             load_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] INIT_GRAY = INIT ^ (INIT >> 1);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [WIDTH-1:0] ld_bin;
    logic             acc;

    // Gray-coded load value back to binary: running XOR from the MSB down
    always_comb begin
        ld_bin = '0;
        acc    = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc       = acc ^ load_val[i];
            ld_bin[i] = acc;
        end
    end

    // Next count: load beats enable, then step in the chosen direction
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_gray ? ld_bin : load_val;
        end else if (en && up_dn) begin
            bin_d  = bin_q + ONE;
            wrap_d = (bin_q == ONES);
        end else if (en) begin
            bin_d  = bin_q - ONE;
            wrap_d = (bin_q == ZERO);
        end
        gray_d = bin_d ^ (bin_d >> 1);
    end

    // Both codes load from the same next value so they never disagree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= INIT;
            gray_q <= INIT_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: three instances share stimulus,
// an arithmetic model predicts each, a negedge monitor compares.
module tb_gray_counter;

    typedef struct {
        logic [63:0] b;
        logic [63:0] g;
        logic        w;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        up_dn = 1'b0;
    logic        load = 1'b0;
    logic        load_gray = 1'b0;
    logic [31:0] load_val = '0;

    logic [3:0]  b_a, g_a, b_c, g_c;
    logic [31:0] b_b, g_b;
    logic        w_a, w_b, w_c;

    int nvec = 0;
    int nerr = 0;

    exp_t sb[3][$];
    longint unsigned mb[3];
    int unsigned wd[3] = '{4, 32, 4};
    longint unsigned ini[3] = '{0, 0, 5};

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(4), .INIT(4'd0)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn),
        .load(load), .load_gray(load_gray), .load_val(load_val[3:0]),
        .bin_out(b_a), .gray_out(g_a), .wrap(w_a)
    );

    gray_counter #(.WIDTH(32), .INIT(32'd0)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn),
        .load(load), .load_gray(load_gray), .load_val(load_val),
        .bin_out(b_b), .gray_out(g_b), .wrap(w_b)
    );

    gray_counter #(.WIDTH(4), .INIT(4'd5)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn),
        .load(load), .load_gray(load_gray), .load_val(load_val[3:0]),
        .bin_out(b_c), .gray_out(g_c), .wrap(w_c)
    );

    function automatic longint unsigned msk(input int unsigned w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    // Binary value is the XOR of every right shift of the Gray word
    function automatic longint unsigned g2b(input longint unsigned g);
        longint unsigned b = 0;
        for (int s = 0; s < 64; s++) b = b ^ (g >> s);
        return b;
    endfunction

    task automatic cmp(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic chk(input string nm, input exp_t e,
                       input logic [63:0] b, input logic [63:0] g,
                       input logic w);
        cmp({nm, ".bin"}, b, e.b);
        cmp({nm, ".gray"}, g, e.g);
        cmp({nm, ".wrap"}, {63'd0, w}, {63'd0, e.w});
    endtask

    // Monitor: outputs are valid every cycle; pop one prediction each
    always @(negedge clk) begin
        exp_t e;
        if (sb[0].size() > 0) begin
            e = sb[0].pop_front();
            chk("w4", e, {60'd0, b_a}, {60'd0, g_a}, w_a);
        end
        if (sb[1].size() > 0) begin
            e = sb[1].pop_front();
            chk("w32", e, {32'd0, b_b}, {32'd0, g_b}, w_b);
        end
        if (sb[2].size() > 0) begin
            e = sb[2].pop_front();
            chk("w4i5", e, {60'd0, b_c}, {60'd0, g_c}, w_c);
        end
    end

    task automatic apply(input logic e_i, input logic u_i, input logic l_i,
                         input logic lg_i, input logic [31:0] lv_i);
        longint unsigned m, v, nb;
        exp_t x;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        en = e_i;
        up_dn = u_i;
        load = l_i;
        load_gray = lg_i;
        load_val = lv_i;
        for (int d = 0; d < 3; d++) begin
            m = msk(wd[d]);
            x.w = 1'b0;
            nb = mb[d];
            if (l_i) begin
                v = longint'(lv_i) & m;
                nb = lg_i ? (g2b(v) & m) : v;
            end else if (e_i && u_i) begin
                x.w = (mb[d] == m);
                nb = (mb[d] + 1) & m;
            end else if (e_i) begin
                x.w = (mb[d] == 0);
                nb = (mb[d] - 1) & m;
            end
            mb[d] = nb;
            x.b = nb;
            x.g = nb ^ (nb >> 1);
            sb[d].push_back(x);
        end
    endtask

    task automatic chk_init(input string nm);
        exp_t x;
        for (int d = 0; d < 3; d++) begin
            x.b = ini[d];
            x.g = ini[d] ^ (ini[d] >> 1);
            x.w = 1'b0;
            case (d)
                0: chk({nm, ".w4"}, x, {60'd0, b_a}, {60'd0, g_a}, w_a);
                1: chk({nm, ".w32"}, x, {32'd0, b_b}, {32'd0, g_b}, w_b);
                default:
                   chk({nm, ".w4i5"}, x, {60'd0, b_c}, {60'd0, g_c}, w_c);
            endcase
        end
    endtask

    // Assert reset between edges, check at once and again across an edge
    task automatic do_reset(input logic busy);
        @(negedge clk);
        #2;
        en = busy;
        up_dn = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_init("rst_now");
        @(posedge clk);
        #1;
        chk_init("rst_hold");
        for (int d = 0; d < 3; d++) mb[d] = ini[d];
    endtask

    initial begin
        logic [31:0] lv;
        int r;

        do_reset(1'b0);

        for (int i = 0; i < 17; i++) apply(1, 1, 0, 0, '0);

        apply(0, 0, 1, 1, 32'h8);
        apply(1, 1, 0, 0, '0);

        do_reset(1'b0);
        apply(1, 0, 0, 0, '0);
        apply(1, 1, 0, 0, '0);

        apply(1, 1, 1, 0, 32'hFFFF_FFFF);
        apply(1, 1, 0, 0, '0);
        apply(0, 1, 0, 0, '0);

        do_reset(1'b0);
        for (int i = 0; i < 3; i++) apply(1, 1, 0, 0, '0);
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) apply(1, 1, 0, 0, '0);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                case ($urandom_range(0, 4))
                    0: lv = 32'h0;
                    1: lv = 32'hFFFF_FFFF;
                    2: lv = 32'hFFFF_FFFE;
                    3: lv = 32'h8000_0000;
                    default: lv = $urandom;
                endcase
                apply(1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)),
                      1'(r < 14),
                      1'($urandom_range(0, 1)),
                      lv);
            end
        end

        @(negedge clk);
        @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            nvec++;
            if (sb[d].size() != 0) begin
                nerr++;
                $display("FAIL drain%0d: got %0d pending expected 0", d,
                         sb[d].size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
# gray_counter

Parametrised, registered up/down counter that presents its value simultaneously in binary and reflected-Gray form. It extends the combinational binary-to-Gray converter into a sequential block with load (binary or Gray source), direction control and wrap detection. It is the pointer generator for async-FIFO and clock-domain-crossing logic: `gray_out` is glitch-free and single-bit-changing, so it is safe to synchronise into another domain.

## Interface

- `WIDTH`, default 32, counter width in bits (legal range 2..64).
- `INIT`, default 0, binary count value applied at reset (`WIDTH` bits, truncated).

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `en`  input  1  count enable; steps the counter by one when high.
- `up_dn`  input  1  direction: 1 = increment, 0 = decrement.
- `load`  input  1  synchronous load of `load_val`; overrides `en`.
- `load_gray`  input  1  qualifies `load`: 1 = `load_val` is Gray-coded, 0 = binary.
- `load_val`  input  WIDTH  load value.
- `bin_out`  output  WIDTH  registered binary count.
- `gray_out`  output  WIDTH  registered Gray code of `bin_out`.
- `wrap`  output  1  one-cycle pulse indicating the last step crossed the all-ones/zero boundary.

One clock; reset is asynchronous and active-low.

## Operation

**State.** The block holds one binary count register `b`. Both `bin_out` and `gray_out` are flops loaded from the same next-state value, so they are always mutually consistent. Gray next value = `b_next ^ (b_next >> 1)`.

**Next-state priority, per rising edge:**
1. `load`=1:
   - `load_gray`=0: `b_next = load_val`.
   - `load_gray`=1: `b_next[WIDTH-1] = load_val[WIDTH-1]`, and `b_next[i] = b_next[i+1] ^ load_val[i]` for lower bits (Gray-to-binary prefix XOR from the MSB).
   - `wrap_next` = 0.
2. Else `en`=1, `up_dn`=1: `b_next = b + 1` modulo 2^WIDTH. `wrap_next` = 1 when `b` was all-ones.
3. Else `en`=1, `up_dn`=0: `b_next = b - 1` modulo 2^WIDTH. `wrap_next` = 1 when `b` was 0.
4. Else: hold `b`; `wrap_next` = 0.

**Gray stepping.** Every count step (cases 2 and 3) changes exactly one bit of `gray_out`. A load may change any number of bits.

**Wrap.** `wrap` is never asserted by a load, even when the loaded value sits on the boundary. Direction may change on any cycle with no penalty.

**Reset (`rst_n`=0, asynchronous):**
- `bin_out` = `INIT`
- `gray_out` = `INIT ^ (INIT >> 1)`
- `wrap` = 0

These values hold for as long as `rst_n` is low. On release, the first rising edge with `rst_n`=1 evaluates the inputs normally. Reset asserted mid-count abandons the count immediately; there is no residual `wrap` pulse.

## Timing

- All outputs are registered. Latency is one cycle from the sampled input to the output.
- There is no combinational path from any input to any output.
- `wrap` is high for exactly the one cycle in which `bin_out` shows the post-wrap value. With `en` held high, `wrap` pulses every 2^WIDTH cycles.
- Inputs are sampled only at the rising edge of `clk`. `load_gray` and `load_val` are don't-care when `load`=0.
- Sustained throughput is one step per cycle, with no bubbles at wrap or on direction change.

## Test plan

- **Reset.** `WIDTH`=4, `INIT`=0: assert `rst_n`=0 asynchronously, between clock edges → `bin_out`=0, `gray_out`=0, `wrap`=0 immediately, without waiting for a clock edge.
- **Up count.** `WIDTH`=4: `en`=1, `up_dn`=1 for 16 cycles from 0 → `gray_out` sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0. `wrap`=1 only on the cycle the count returns to 0. Every step has Hamming distance 1.
- **Gray load, then step up.** `WIDTH`=4: `load`=1, `load_gray`=1, `load_val`=4'h8 → `bin_out`=F, `gray_out`=8, `wrap`=0. Next cycle `en`=1, `up_dn`=1 → `bin_out`=0, `gray_out`=0, `wrap`=1.
- **Down count and direction change.** `WIDTH`=4 from 0: `en`=1, `up_dn`=0 → `bin_out`=F, `gray_out`=8, `wrap`=1. Next cycle with `up_dn`=1 → `bin_out`=0, `wrap`=1.
- **Load priority.** `WIDTH`=32: `load`=1, `en`=1, `load_gray`=0, `load_val`=32'hFFFF_FFFF on the same edge → `bin_out`=FFFF_FFFF, `gray_out`=8000_0000, `wrap`=0. Next `en`=1, `up_dn`=1 → `bin_out`=0, `wrap`=1.
- **Non-zero INIT and mid-count reset.** `INIT`=5, `WIDTH`=4: count up 3 steps to 8, then pulse `rst_n` low → outputs return to `bin_out`=5, `gray_out`=7, `wrap`=0 immediately. After release, counting resumes from 5.
